pipeline_run_controller: RTL and testbench
==========================================

// Module: pipeline_run_controller
// PURPOSE
//  Run/step/halt sequencer for the 4-stage 8-bit pipelined core (IF, ID, EX, WB).
//  Gates instruction fetch and tracks a valid bit per pipeline register so that
//  halts drain cleanly, with no partial writeback.
//  Provides a PC breakpoint and saturating cycle/retire counters for debug and bench monitoring.
//  Sits beside the core: fetch_en enables the PC/IF update; wb_commit gates the register-file write.
// PARAMETERS
//  DEPTH  3   pipeline registers after fetch (IF/ID, ID/EX, EX/WB); legal range 2..8
//  CNT_W  16  width of cycle_cnt and retired_cnt
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high; returns the block to IDLE
//  start        in   1      level; begin free-running execution
//  step         in   1      level; execute exactly one instruction
//  halt_req     in   1      level; stop fetching and drain the pipeline
//  bp_en        in   1      enable the PC breakpoint
//  bp_pc        in   8      breakpoint address
//  pc           in   8      address of the instruction the core fetches this cycle
//  fetch_en     out  1      core advances PC and latches the instruction this cycle
//  stage_valid  out  DEPTH  bit i = pipeline register i holds a real instruction
//  wb_commit    out  1      = stage_valid[DEPTH-1]; enables the regfile write
//  busy         out  1      state is RUN, STEP or DRAIN
//  halted       out  1      state is HALTED
//  bp_hit       out  1      sticky; set when a breakpoint caused the halt
//  cycle_cnt    out  CNT_W  cycles spent busy, saturating
//  retired_cnt  out  CNT_W  instructions committed, saturating
// BEHAVIOUR
//  Reset values: state=IDLE, stage_valid=0, bp_hit=0, bp_skip=0, counters=0.
//  Resulting outputs: fetch_en=0, wb_commit=0, busy=0, halted=0.
//  Pipeline tracking (every cycle, all states):
//   - stage_valid <= {stage_valid[DEPTH-2:0], fetch_en}
//   - fetch_en is a combinational decode of state and inputs.
//  States and transitions:
//   - IDLE: fetch_en=0.
//     start -> RUN; else step -> STEP. start has priority over step.
//   - RUN: fetch_en=1 unless a stop condition holds this cycle.
//     Stop condition = halt_req, or bp_en && pc==bp_pc && !bp_skip.
//     On a stop condition: fetch_en=0 in that same cycle, go to DRAIN.
//     If the breakpoint caused the stop and halt_req=0, set bp_hit.
//     If halt_req=1, it wins and bp_hit stays 0.
//     The instruction at bp_pc is NOT fetched.
//   - STEP: fetch_en=1 for exactly one cycle, then -> DRAIN.
//     halt_req and the breakpoint are ignored in STEP.
//   - DRAIN: fetch_en=0.
//     When stage_valid[DEPTH-2:0]==0 -> HALTED.
//     The last instruction commits in that exit cycle.
//   - HALTED: fetch_en=0, stage_valid==0.
//     start -> RUN with bp_skip=1; else step -> STEP with bp_skip=1.
//     bp_hit is cleared on leaving HALTED.
//  bp_skip: cleared on the first cycle with fetch_en=1.
//   Resuming at a breakpoint address therefore does not re-trigger immediately.
//  Latency:
//   - halt_req in RUN with a full pipeline -> halted=1 exactly DEPTH cycles later.
//   - step from HALTED -> one wb_commit pulse DEPTH+1 cycles later, halted DEPTH+2 cycles later.
//  Counters:
//   - cycle_cnt +1 in every busy cycle.
//   - retired_cnt +1 in every cycle with wb_commit=1.
//   - Both hold at 2^CNT_W-1 (no wrap). Only reset clears them.
//  Reset mid-operation (any state): everything returns to reset values next edge.
//   In-flight stage_valid bits are discarded and no commit occurs after reset.
//  start/step/halt_req asserted while busy are ignored, except halt_req in RUN.
// STRUCTURE
//  Shared package (core_pkg): state encoding localparams (IDLE, RUN, STEP, DRAIN, HALTED),
//  DEPTH default, core data width 8.
//  One sub-module: sat_counter (param W; inputs clk, reset, inc; output count; saturating).
//  It is instantiated twice.
//  FSM, valid shifter and breakpoint compare live in the top module.
// TESTING
//  1. Reset; start=1 held 10 cycles -> fetch_en=1 from cycle 1.
//     wb_commit first high at cycle 4; retired_cnt=7 after cycle 10.
//  2. RUN with full pipeline; halt_req pulse at cycle t -> fetch_en=0 at t.
//     stage_valid 110, 100, 000 at t+1..t+3; halted=1 at t+3; bp_hit=0.
//  3. bp_en=1, bp_pc=0x05, pc counting 0,1,2... -> fetch_en=0 when pc=0x05.
//     halted and bp_hit=1 three cycles later. Then start -> pc=0x05 fetched, no re-trigger.
//  4. From HALTED, step for 1 cycle -> exactly one fetch_en pulse.
//     One wb_commit pulse; retired_cnt +1; back to HALTED.
//  5. CNT_W=4; run 20 cycles -> cycle_cnt=15 and held; retired_cnt=15 and held.
//  6. reset=1 during DRAIN with stage_valid=110 -> next cycle IDLE.
//     stage_valid=0, counters=0, no wb_commit afterwards.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 4-stage 8-bit core: controller state encoding and default sizes.
package core_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH_DEF = 3;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the pipelined core: gates fetch, tracks per-stage valid
// bits so halts drain cleanly, and provides a PC breakpoint plus debug counters.
module pipeline_run_controller
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_bp_en,
  input  logic [DATA_W-1:0] i_bp_pc,
  input  logic [DATA_W-1:0] i_pc,
  output logic              o_fetch_en,
  output logic [DEPTH-1:0]  o_stage_valid,
  output logic              o_wb_commit,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_bp_hit,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_retired_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH-1:0] r_stage_valid;
  logic             r_bp_hit;
  logic             r_bp_skip;
  logic             w_bp_hit_nxt;
  logic             w_bp_skip_nxt;
  logic             w_fetch_en;
  logic             w_bp_match;
  logic             w_stop;
  logic             w_drained;
  logic             w_busy;

  // A resumed run skips the breakpoint until its first fetch, so it does not re-trigger at bp_pc.
  assign w_bp_match = i_bp_en && (i_pc == i_bp_pc) && !r_bp_skip;
  assign w_stop     = i_halt_req || w_bp_match;
  assign w_drained  = (r_stage_valid[DEPTH-2:0] == '0);
  assign w_busy     = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_en    = 1'b0;
    w_bp_hit_nxt  = r_bp_hit;
    w_bp_skip_nxt = r_bp_skip;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else if (i_step) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = ST_DRAIN;
          if (!i_halt_req) begin
            w_bp_hit_nxt = 1'b1;
          end
        end else begin
          w_fetch_en    = 1'b1;
          w_bp_skip_nxt = 1'b0;
        end
      end
      ST_STEP: begin
        w_fetch_en    = 1'b1;
        w_bp_skip_nxt = 1'b0;
        w_state_nxt   = ST_DRAIN;
      end
      // The youngest in-flight instruction reaches the last register on the exit cycle.
      ST_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (i_start) begin
          w_state_nxt   = ST_RUN;
          w_bp_skip_nxt = 1'b1;
          w_bp_hit_nxt  = 1'b0;
        end else if (i_step) begin
          w_state_nxt   = ST_STEP;
          w_bp_skip_nxt = 1'b1;
          w_bp_hit_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_stage_valid <= '0;
      r_bp_hit      <= 1'b0;
      r_bp_skip     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_stage_valid <= {r_stage_valid[DEPTH-2:0], w_fetch_en};
      r_bp_hit      <= w_bp_hit_nxt;
      r_bp_skip     <= w_bp_skip_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_busy),
    .o_count (o_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (r_stage_valid[DEPTH-1]),
    .o_count (o_retired_cnt)
  );

  assign o_fetch_en    = w_fetch_en;
  assign o_stage_valid = r_stage_valid;
  assign o_wb_commit   = r_stage_valid[DEPTH-1];
  assign o_busy        = w_busy;
  assign o_halted      = (r_state == ST_HALTED);
  assign o_bp_hit      = r_bp_hit;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: directed scenarios plus random stimulus, all checked
// each cycle against a model that tracks fetched instructions by their fetch cycle.
module tb_pipeline_run_controller;

  localparam int DEPTH   = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STEP   = 2;
  localparam int M_DRAIN  = 3;
  localparam int M_HALTED = 4;

  logic             i_clk;
  logic             i_reset;
  logic             i_start;
  logic             i_step;
  logic             i_halt_req;
  logic             i_bp_en;
  logic [7:0]       i_bp_pc;
  logic [7:0]       i_pc;
  logic             o_fetch_en;
  logic [DEPTH-1:0] o_stage_valid;
  logic             o_wb_commit;
  logic             o_busy;
  logic             o_halted;
  logic             o_bp_hit;
  logic [CNT_W-1:0] o_cycle_cnt;
  logic [CNT_W-1:0] o_retired_cnt;

  logic               s_fetch_en;
  logic [DEPTH-1:0]   s_stage_valid;
  logic               s_wb_commit;
  logic               s_busy;
  logic               s_halted;
  logic               s_bp_hit;
  logic [CNT_W_S-1:0] s_cycle_cnt;
  logic [CNT_W_S-1:0] s_retired_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_st;
  logic       m_skip;
  logic       m_hit;
  int         m_cyc;
  int         m_ret;
  int         m_n;
  int         m_fq[$];
  logic [7:0] m_pc;

  pipeline_run_controller #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_step(i_step),
    .i_halt_req(i_halt_req), .i_bp_en(i_bp_en), .i_bp_pc(i_bp_pc), .i_pc(i_pc),
    .o_fetch_en(o_fetch_en), .o_stage_valid(o_stage_valid), .o_wb_commit(o_wb_commit),
    .o_busy(o_busy), .o_halted(o_halted), .o_bp_hit(o_bp_hit),
    .o_cycle_cnt(o_cycle_cnt), .o_retired_cnt(o_retired_cnt)
  );

  pipeline_run_controller #(.DEPTH(DEPTH), .CNT_W(CNT_W_S)) dut_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_step(i_step),
    .i_halt_req(i_halt_req), .i_bp_en(i_bp_en), .i_bp_pc(i_bp_pc), .i_pc(i_pc),
    .o_fetch_en(s_fetch_en), .o_stage_valid(s_stage_valid), .o_wb_commit(s_wb_commit),
    .o_busy(s_busy), .o_halted(s_halted), .o_bp_hit(s_bp_hit),
    .o_cycle_cnt(s_cycle_cnt), .o_retired_cnt(s_retired_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, got, exp, m_n);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_st   = M_IDLE;
    m_skip = 1'b0;
    m_hit  = 1'b0;
    m_cyc  = 0;
    m_ret  = 0;
    m_pc   = 8'h00;
    m_fq.delete();
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic cyc(input logic rst, input logic st, input logic sp, input logic hr,
                     input logic be, input logic [7:0] bpc);
    logic             e_fetch;
    logic             e_commit;
    logic             e_busy;
    logic             stop;
    logic             bpm;
    logic             drained;
    logic [DEPTH-1:0] e_sv;
    @(negedge i_clk);
    i_reset    = rst;
    i_start    = st;
    i_step     = sp;
    i_halt_req = hr;
    i_bp_en    = be;
    i_bp_pc    = bpc;
    i_pc       = m_pc;
    #1;
    e_busy  = (m_st == M_RUN) || (m_st == M_STEP) || (m_st == M_DRAIN);
    bpm     = be && (m_pc == bpc) && !m_skip;
    stop    = hr || bpm;
    e_fetch = ((m_st == M_RUN) && !stop) || (m_st == M_STEP);
    e_sv     = '0;
    e_commit = 1'b0;
    drained  = 1'b1;
    foreach (m_fq[k]) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_fq[k] == m_n - 1 - i) e_sv[i] = 1'b1;
      end
      if (m_fq[k] == m_n - DEPTH) e_commit = 1'b1;
      if (m_fq[k] > m_n - DEPTH) drained = 1'b0;
    end
    check("fetch_en",    32'(o_fetch_en),    32'(e_fetch));
    check("stage_valid", 32'(o_stage_valid), 32'(e_sv));
    check("wb_commit",   32'(o_wb_commit),   32'(e_commit));
    check("busy",        32'(o_busy),        32'(e_busy));
    check("halted",      32'(o_halted),      32'(m_st == M_HALTED));
    check("bp_hit",      32'(o_bp_hit),      32'(m_hit));
    check("cycle_cnt",   32'(o_cycle_cnt),   32'(sat(m_cyc, CNT_W)));
    check("retired_cnt", 32'(o_retired_cnt), 32'(sat(m_ret, CNT_W)));
    check("cycle_cnt_w4",   32'(s_cycle_cnt),   32'(sat(m_cyc, CNT_W_S)));
    check("retired_cnt_w4", 32'(s_retired_cnt), 32'(sat(m_ret, CNT_W_S)));
    if (rst) begin
      model_reset();
    end else begin
      if (e_busy) m_cyc++;
      if (e_commit) m_ret++;
      if (e_fetch) begin
        m_fq.push_back(m_n);
        m_skip = 1'b0;
        m_pc   = (m_pc + 8'h01) & 8'h0F;
      end
      case (m_st)
        M_IDLE: begin
          if (st) m_st = M_RUN;
          else if (sp) m_st = M_STEP;
        end
        M_RUN: begin
          if (stop) begin
            m_st = M_DRAIN;
            if (!hr) m_hit = 1'b1;
          end
        end
        M_STEP:  m_st = M_DRAIN;
        M_DRAIN: if (drained) m_st = M_HALTED;
        default: begin
          if (st || sp) begin
            m_st   = st ? M_RUN : M_STEP;
            m_skip = 1'b1;
            m_hit  = 1'b0;
          end
        end
      endcase
      while (m_fq.size() > 0 && m_fq[0] < m_n - DEPTH) void'(m_fq.pop_front());
    end
    m_n++;
  endtask

  initial begin
    int         ret_before;
    logic [7:0] rbpc;
    logic       rbe;
    i_reset = 1'b1; i_start = 1'b0; i_step = 1'b0; i_halt_req = 1'b0;
    i_bp_en = 1'b0; i_bp_pc = 8'h00; i_pc = 8'h00;
    m_n = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_fetch_en",    32'(o_fetch_en),    32'(0));
    check("rst_stage_valid", 32'(o_stage_valid), 32'(0));
    check("rst_wb_commit",   32'(o_wb_commit),   32'(0));
    check("rst_busy",        32'(o_busy),        32'(0));
    check("rst_halted",      32'(o_halted),      32'(0));
    check("rst_bp_hit",      32'(o_bp_hit),      32'(0));
    check("rst_cycle_cnt",   32'(o_cycle_cnt),   32'(0));
    check("rst_retired_cnt", 32'(o_retired_cnt), 32'(0));

    // Free run from IDLE: commits begin at cycle 4, seven by the end of cycle 10
    for (int c = 0; c < 11; c++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge i_clk); #1;
    check("t1_retired", 32'(o_retired_cnt), 32'(7));
    check("t1_cycles",  32'(o_cycle_cnt),   32'(10));

    // Halt pulse with a full pipeline: halted exactly DEPTH cycles later
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t2_halted", 32'(o_halted), 32'(1));
    check("t2_bp_hit", 32'(o_bp_hit), 32'(0));

    // Breakpoint at 0x05, then resume from it without re-triggering
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
    for (int c = 0; c < 9; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    check("t3_halted", 32'(o_halted), 32'(1));
    check("t3_bp_hit", 32'(o_bp_hit), 32'(1));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    check("t3_refetch", 32'(o_fetch_en), 32'(1));
    check("t3_hit_clr", 32'(o_bp_hit),   32'(0));
    for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05);
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05);

    // Single step from HALTED retires exactly one instruction
    ret_before = sat(m_ret, CNT_W);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_retired", 32'(o_retired_cnt), 32'(ret_before + 1));
    check("t4_halted",  32'(o_halted),      32'(1));

    // Narrow counters saturate at 15
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge i_clk); #1;
    check("t5_cycle_w4",   32'(s_cycle_cnt),   32'(15));
    check("t5_retired_w4", 32'(s_retired_cnt), 32'(15));

    // Reset while draining discards in-flight instructions
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge i_clk); #1;
    check("t6_stage_valid", 32'(o_stage_valid), 32'(0));
    check("t6_cycle_cnt",   32'(o_cycle_cnt),   32'(0));
    check("t6_retired_cnt", 32'(o_retired_cnt), 32'(0));
    check("t6_busy",        32'(o_busy),        32'(0));
    for (int c = 0; c < 5; c++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic
    rbpc = 8'h05;
    rbe  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) begin
        rbe  = 1'($urandom_range(1));
        rbpc = 8'($urandom_range(15));
      end
      cyc($urandom_range(299) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
          $urandom_range(9) == 0, rbe, rbpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
